// File: rtl/logic_unit_pkg.sv
// Shared types and constants for the pipelined bitwise logic unit.
// The op encodings match the execute-stage decoder.
package logic_unit_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_ORR  = 3'b001,
        OP_EOR  = 3'b010,
        OP_BIC  = 3'b011,
        OP_ORN  = 3'b100,
        OP_EON  = 3'b101,
        OP_MOVA = 3'b110,
        OP_MVNB = 3'b111
    } op_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef logic [3:0] nzcv_t;

    // Logic ops never produce carry or overflow, so only N and Z are live.
    function automatic nzcv_t logic_flags(input logic n, input logic z);
        nzcv_t f;
        f         = 4'b0000;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = 1'b0;
        f[FLAG_V] = 1'b0;
        return f;
    endfunction

endpackage

// File: rtl/logic_unit_pipe_if.sv
// Op/result handshake bundle between the issue logic, the logic unit and writeback.
interface logic_unit_pipe_if #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 5
);
    import logic_unit_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             set_flags;
    logic [TAG_W-1:0] tag_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [TAG_W-1:0] tag_out;
    nzcv_t            res_flags;
    nzcv_t            nzcv;

    modport master (
        output in_valid, a, b, op, set_flags, tag_in, out_ready,
        input  in_ready, out_valid, result, tag_out, res_flags, nzcv
    );

    modport slave (
        input  in_valid, a, b, op, set_flags, tag_in, out_ready,
        output in_ready, out_valid, result, tag_out, res_flags, nzcv
    );

endinterface

// File: rtl/logic_unit_pipe_chk.sv
// Protocol properties of the logic unit pipeline, checked on the live signals.
module logic_unit_pipe_chk
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int TAG_W = 5
) (
    input logic             clk,
    input logic             reset_n,
    input logic             flush,
    input logic             in_ready,
    input logic             out_valid,
    input logic             out_ready,
    input logic [WIDTH-1:0] result,
    input logic [TAG_W-1:0] tag_out,
    input logic             s2_setf,
    input nzcv_t            nzcv
);

    property p_out_hold;
        @(posedge clk) disable iff (!reset_n)
            (out_valid && !out_ready && !flush) |=> (out_valid && $stable(result) && $stable(tag_out));
    endproperty

    property p_flush_blocks_input;
        @(posedge clk) disable iff (!reset_n)
            flush |-> !in_ready;
    endproperty

    property p_nzcv_only_on_flag_handshake;
        @(posedge clk) disable iff (!reset_n)
            !(out_valid && out_ready && s2_setf) |=> $stable(nzcv);
    endproperty

    a_out_hold:    assert property (p_out_hold);
    a_flush_block: assert property (p_flush_blocks_input);
    a_nzcv_stable: assert property (p_nzcv_only_on_flag_handshake);

endmodule

// File: rtl/zero_detect_tree.sv
// Second-level zero detect: OR-reduces the per-group OR vector and inverts it.
module zero_detect_tree #(
    parameter int N = 16
) (
    input  logic [N-1:0] grp_vec,
    output logic         zero
);

    logic any_s;

    // Fold every group bit into a single "anything set" flag.
    always_comb begin
        any_s = 1'b0;
        for (int i = 0; i < N; i++) begin
            any_s = any_s | grp_vec[i];
        end
    end

    assign zero = ~any_s;

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready handshake, flush,
// destination tag pass-through and an architectural NZCV register.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int GROUP = 4,
    parameter int TAG_W = 5
) (
    input logic             clk,
    input logic             reset_n,
    input logic             flush,
    logic_unit_pipe_if.slave bus
);

    localparam int NGRP = WIDTH / GROUP;

    logic [WIDTH-1:0] op_res_s;
    logic [NGRP-1:0]  grp_s;
    logic             accept_s;
    logic             s2_adv_s;
    logic             in_ready_s;
    logic             out_hs_s;
    logic             z_s;
    nzcv_t            flags_s;

    logic             s1_valid_r;
    logic [WIDTH-1:0] s1_result_r;
    logic [TAG_W-1:0] s1_tag_r;
    logic             s1_setf_r;
    logic [NGRP-1:0]  s1_grp_r;

    logic             s2_valid_r;
    logic [WIDTH-1:0] s2_result_r;
    logic [TAG_W-1:0] s2_tag_r;
    logic             s2_setf_r;
    nzcv_t            s2_flags_r;
    nzcv_t            nzcv_r;

    // Stage 2 takes s1 when it is empty or draining; s1 refills behind it in the same edge.
    assign s2_adv_s   = s1_valid_r & (~s2_valid_r | bus.out_ready);
    assign in_ready_s = (~s1_valid_r | s2_adv_s) & ~flush;
    assign accept_s   = bus.in_valid & in_ready_s;
    assign out_hs_s   = s2_valid_r & bus.out_ready;

    // Operand logic for the eight encodings.
    always_comb begin
        op_res_s = {WIDTH{1'b0}};
        case (op_t'(bus.op))
            OP_AND:  op_res_s = bus.a & bus.b;
            OP_ORR:  op_res_s = bus.a | bus.b;
            OP_EOR:  op_res_s = bus.a ^ bus.b;
            OP_BIC:  op_res_s = bus.a & ~bus.b;
            OP_ORN:  op_res_s = bus.a | ~bus.b;
            OP_EON:  op_res_s = bus.a ^ ~bus.b;
            OP_MOVA: op_res_s = bus.a;
            OP_MVNB: op_res_s = ~bus.b;
            default: op_res_s = {WIDTH{1'b0}};
        endcase
    end

    // First-level zero detect: one OR per GROUP-bit slice, finished in stage 2.
    always_comb begin
        grp_s = {NGRP{1'b0}};
        for (int g = 0; g < NGRP; g++) begin
            grp_s[g] = |op_res_s[g*GROUP +: GROUP];
        end
    end

    zero_detect_tree #(
        .N (NGRP)
    ) u_zero_detect (
        .grp_vec (s1_grp_r),
        .zero    (z_s)
    );

    // Flags of the op currently in stage 1, captured into stage 2 on advance.
    always_comb begin
        flags_s = logic_flags(s1_result_r[WIDTH-1], z_s);
    end

    // Stage 1 register: flush drops the op; data is left as is since valid gates it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_r  <= 1'b0;
            s1_result_r <= {WIDTH{1'b0}};
            s1_tag_r    <= {TAG_W{1'b0}};
            s1_setf_r   <= 1'b0;
            s1_grp_r    <= {NGRP{1'b0}};
        end else if (flush) begin
            s1_valid_r  <= 1'b0;
        end else if (accept_s) begin
            s1_valid_r  <= 1'b1;
            s1_result_r <= op_res_s;
            s1_tag_r    <= bus.tag_in;
            s1_setf_r   <= bus.set_flags;
            s1_grp_r    <= grp_s;
        end else if (s2_adv_s) begin
            s1_valid_r  <= 1'b0;
        end else begin
            s1_valid_r  <= s1_valid_r;
        end
    end

    // Stage 2 / output register: holds while stalled, drops after a handshake with nothing behind.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid_r  <= 1'b0;
            s2_result_r <= {WIDTH{1'b0}};
            s2_tag_r    <= {TAG_W{1'b0}};
            s2_setf_r   <= 1'b0;
            s2_flags_r  <= 4'b0000;
        end else if (flush) begin
            s2_valid_r  <= 1'b0;
        end else if (s2_adv_s) begin
            s2_valid_r  <= 1'b1;
            s2_result_r <= s1_result_r;
            s2_tag_r    <= s1_tag_r;
            s2_setf_r   <= s1_setf_r;
            s2_flags_r  <= flags_s;
        end else if (bus.out_ready) begin
            s2_valid_r  <= 1'b0;
        end else begin
            s2_valid_r  <= s2_valid_r;
        end
    end

    // Architectural flags commit on the output handshake, even one coincident with flush.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nzcv_r <= 4'b0000;
        end else if (out_hs_s && s2_setf_r) begin
            nzcv_r <= s2_flags_r;
        end else begin
            nzcv_r <= nzcv_r;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = s2_valid_r;
    assign bus.result    = s2_result_r;
    assign bus.tag_out   = s2_tag_r;
    assign bus.res_flags = s2_flags_r;
    assign bus.nzcv      = nzcv_r;

    logic_unit_pipe_chk #(
        .WIDTH (WIDTH),
        .TAG_W (TAG_W)
    ) u_chk (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_ready  (in_ready_s),
        .out_valid (s2_valid_r),
        .out_ready (bus.out_ready),
        .result    (s2_result_r),
        .tag_out   (s2_tag_r),
        .s2_setf   (s2_setf_r),
        .nzcv      (nzcv_r)
    );

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: a 64-bit/4-bit-group unit and an
// 8-bit single-group unit share stimulus and are checked against a reference model.
module tb_logic_unit_pipe;
    import logic_unit_pkg::*;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic flush   = 1'b0;

    always #5 clk = ~clk;

    logic_unit_pipe_if #(.WIDTH(64), .TAG_W(5)) b64 ();
    logic_unit_pipe_if #(.WIDTH(8),  .TAG_W(5)) b8 ();

    logic_unit_pipe #(.WIDTH(64), .GROUP(4), .TAG_W(5)) dut64 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .bus(b64)
    );
    logic_unit_pipe #(.WIDTH(8), .GROUP(8), .TAG_W(5)) dut8 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .bus(b8)
    );

    typedef struct packed {
        logic [63:0] res;
        logic [4:0]  tag;
        logic [3:0]  fl;
        logic        sf;
    } exp_t;

    exp_t q64[$];
    exp_t q8[$];
    logic [3:0] mn64 = 4'b0000;
    logic [3:0] mn8  = 4'b0000;
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: op table applied to whole words, truncated to w bits; N=msb, Z=(result==0).
    function automatic exp_t model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                                   input int w, input logic sf, input logic [4:0] tag);
        exp_t e;
        logic [63:0] r;
        logic [63:0] m;
        case (op)
            3'd0:    r = a & b;
            3'd1:    r = a | b;
            3'd2:    r = a ^ b;
            3'd3:    r = a & ~b;
            3'd4:    r = a | ~b;
            3'd5:    r = ~(a ^ b);
            3'd6:    r = a;
            default: r = ~b;
        endcase
        m = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        r = r & m;
        e.res = r;
        e.tag = tag;
        e.sf  = sf;
        e.fl  = {r[w-1], (r == 64'd0), 2'b00};
        return e;
    endfunction

    // Issue side of the scoreboard: record each accepted op, forget everything on flush/reset.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q64.delete();
            q8.delete();
        end else if (flush) begin
            q64.delete();
            q8.delete();
        end else begin
            if (b64.in_valid && b64.in_ready)
                q64.push_back(model(b64.op, b64.a, b64.b, 64, b64.set_flags, b64.tag_in));
            if (b8.in_valid && b8.in_ready)
                q8.push_back(model(b8.op, {56'd0, b8.a}, {56'd0, b8.b}, 8, b8.set_flags, b8.tag_in));
        end
    end

    // Output monitor, 64-bit unit.
    always @(negedge clk) begin
        if (!reset_n) begin
            mn64 = 4'b0000;
        end else begin
            cmp("nzcv64", {60'd0, b64.nzcv}, {60'd0, mn64});
            if (b64.out_valid && b64.out_ready) begin
                if (q64.size() == 0) begin
                    cmp("q64_occupancy", 64'(q64.size()), 64'd1);
                end else begin
                    exp_t e;
                    e = q64.pop_front();
                    cmp("res64", b64.result, e.res);
                    cmp("tag64", {59'd0, b64.tag_out}, {59'd0, e.tag});
                    cmp("flags64", {60'd0, b64.res_flags}, {60'd0, e.fl});
                    if (e.sf) mn64 = e.fl;
                end
            end
        end
    end

    // Output monitor, 8-bit single-group unit.
    always @(negedge clk) begin
        if (!reset_n) begin
            mn8 = 4'b0000;
        end else begin
            cmp("nzcv8", {60'd0, b8.nzcv}, {60'd0, mn8});
            if (b8.out_valid && b8.out_ready) begin
                if (q8.size() == 0) begin
                    cmp("q8_occupancy", 64'(q8.size()), 64'd1);
                end else begin
                    exp_t e;
                    e = q8.pop_front();
                    cmp("res8", {56'd0, b8.result}, e.res);
                    cmp("tag8", {59'd0, b8.tag_out}, {59'd0, e.tag});
                    cmp("flags8", {60'd0, b8.res_flags}, {60'd0, e.fl});
                    if (e.sf) mn8 = e.fl;
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic sf, input logic [4:0] tag);
        b64.in_valid = v; b64.op = op; b64.a = a; b64.b = b; b64.set_flags = sf; b64.tag_in = tag;
        b8.in_valid  = v; b8.op  = op; b8.a  = a[7:0]; b8.b = b[7:0]; b8.set_flags = sf; b8.tag_in = tag;
    endtask

    task automatic set_ready(input logic r);
        b64.out_ready = r;
        b8.out_ready  = r;
    endtask

    // Present an op and hold it until accepted (bounded); returns at posedge+1.
    task automatic send(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic sf, input logic [4:0] tag);
        logic acc;
        acc = 1'b0;
        drive(1'b1, op, a, b, sf, tag);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            acc = b64.in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        cmp("send_accept", {63'd0, acc}, 64'd1);
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 64'd0, 64'd0, 1'b0, 5'd0);
    endtask

    task automatic drain();
        idle();
        set_ready(1'b1);
        for (int k = 0; k < 50; k++) begin
            if (q64.size() == 0 && q8.size() == 0) break;
            @(posedge clk);
            #1;
        end
        cmp("drain64", 64'(q64.size()), 64'd0);
        cmp("drain8", 64'(q8.size()), 64'd0);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        idle();
        set_ready(1'b1);
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Reset state
        @(negedge clk);
        cmp("rst_out_valid", {63'd0, b64.out_valid}, 64'd0);
        cmp("rst_in_ready", {63'd0, b64.in_ready}, 64'd1);
        cmp("rst_result", b64.result, 64'd0);
        cmp("rst_tag", {59'd0, b64.tag_out}, 64'd0);
        cmp("rst_flags", {60'd0, b64.res_flags}, 64'd0);
        cmp("rst_nzcv", {60'd0, b64.nzcv}, 64'd0);
        @(posedge clk); #1;

        // Single EOR, latency t+2
        drive(1'b1, 3'b010, 64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1, 5'd1);
        @(negedge clk);
        cmp("eor_in_ready", {63'd0, b64.in_ready}, 64'd1);
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        cmp("eor_lat_t1", {63'd0, b64.out_valid}, 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        cmp("eor_lat_t2", {63'd0, b64.out_valid}, 64'd1);
        cmp("eor_result", b64.result, 64'hF0F0_0F0F_F0F0_0F0F);
        cmp("eor_flags", {60'd0, b64.res_flags}, 64'h8);
        @(posedge clk); #1;
        @(negedge clk);
        cmp("eor_nzcv", {60'd0, b64.nzcv}, 64'h8);
        @(posedge clk); #1;

        // ANDS -> zero, then ORR without flags leaves nzcv
        send(3'b000, {16{4'hA}}, {16{4'h5}}, 1'b1, 5'd2);
        send(3'b001, {16{4'hA}}, {16{4'h5}}, 1'b0, 5'd3);
        idle();
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        cmp("and_orr_nzcv", {60'd0, b64.nzcv}, 64'h4);
        @(posedge clk); #1;

        // Stream of 8 with 3-cycle output stall
        set_ready(1'b0);
        send($urandom_range(0, 7), rnd64(), rnd64(), 1'b0, 5'd0);
        send($urandom_range(0, 7), rnd64(), rnd64(), 1'b0, 5'd1);
        ra = rnd64();
        rb = rnd64();
        drive(1'b1, 3'b011, ra, rb, 1'b0, 5'd2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cmp("full_in_ready", {63'd0, b64.in_ready}, 64'd0);
            cmp("full_out_valid", {63'd0, b64.out_valid}, 64'd1);
            cmp("full_tag_hold", {59'd0, b64.tag_out}, 64'd0);
            if (q64.size() != 0) cmp("full_result_hold", b64.result, q64[0].res);
            @(posedge clk); #1;
        end
        set_ready(1'b1);
        send(3'b011, ra, rb, 1'b0, 5'd2);
        for (int t = 3; t < 8; t++) send($urandom_range(0, 7), rnd64(), rnd64(), 1'b0, 5'(t));
        drain();

        // Flush with both stages full and an op presented
        set_ready(1'b0);
        send(3'b000, 64'd0, 64'd0, 1'b1, 5'd8);
        send(3'b111, 64'd0, 64'd0, 1'b1, 5'd9);
        drive(1'b1, 3'b001, rnd64(), rnd64(), 1'b1, 5'd10);
        flush = 1'b1;
        @(negedge clk);
        cmp("flush_in_ready", {63'd0, b64.in_ready}, 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        idle();
        @(negedge clk);
        cmp("flush_out_valid", {63'd0, b64.out_valid}, 64'd0);
        cmp("flush_nzcv", {60'd0, b64.nzcv}, 64'h4);
        @(posedge clk); #1;
        @(negedge clk);
        cmp("flush_no_accept", {63'd0, b64.out_valid}, 64'd0);
        @(posedge clk); #1;
        set_ready(1'b1);
        send(3'b110, 64'h8000_0000_0000_0001, 64'd0, 1'b1, 5'd11);
        idle();
        @(negedge clk);
        cmp("post_flush_t1", {63'd0, b64.out_valid}, 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        cmp("post_flush_t2", {63'd0, b64.out_valid}, 64'd1);
        cmp("post_flush_tag", {59'd0, b64.tag_out}, 64'd11);
        @(posedge clk); #1;
        drain();

        // Randomised traffic over all ops with stalls and occasional flush
        for (int c = 0; c < 800; c++) begin
            ra = rnd64();
            rb = rnd64();
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ~ra;
                2:       ra = 64'd0;
                default: ;
            endcase
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), ra, rb,
                  $urandom_range(0, 1), 5'($urandom_range(0, 31)));
            set_ready($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 31) == 0);
            @(posedge clk); #1;
        end
        flush = 1'b0;
        drain();

        // Reset mid-operation
        set_ready(1'b0);
        send(3'b010, rnd64(), rnd64(), 1'b1, 5'd20);
        send(3'b100, rnd64(), rnd64(), 1'b1, 5'd21);
        idle();
        #2 reset_n = 1'b0;
        #1;
        cmp("midrst_out_valid", {63'd0, b64.out_valid}, 64'd0);
        cmp("midrst_result", b64.result, 64'd0);
        cmp("midrst_tag", {59'd0, b64.tag_out}, 64'd0);
        cmp("midrst_flags", {60'd0, b64.res_flags}, 64'd0);
        cmp("midrst_nzcv", {60'd0, b64.nzcv}, 64'd0);
        cmp("midrst_nzcv8", {60'd0, b8.nzcv}, 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        set_ready(1'b1);
        @(negedge clk);
        cmp("postrst_in_ready", {63'd0, b64.in_ready}, 64'd1);
        cmp("postrst_out_valid", {63'd0, b64.out_valid}, 64'd0);
        @(posedge clk); #1;
        send(3'b101, rnd64(), rnd64(), 1'b1, 5'd22);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
